// File: rtl/uart_tx_485.sv
// uart_tx_485: RS-485 UART transmitter (8N1, LSB first) with DE lead/guard timing.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module uart_tx_485 #(
  parameter int LEAD_TICKS  = 16,
  parameter int GUARD_TICKS = 16
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       clk16,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       txd,
  output logic       de
);
  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    GUARD
  } state_t;
  state_t      state_q, state_d;
  logic        clk16_q, tick, bit_end;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [7:0]  lcnt_q, lcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bidx_q, bidx_d;
  logic        txd_q, txd_d;
  logic        done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif
  always_comb begin
    tick    = clk16 & ~clk16_q;
    bit_end = tick && tcnt_q == 4'd15;
    state_d = state_q;
    tcnt_d  = tcnt_q + {3'd0, tick};
    lcnt_d  = lcnt_q + {7'd0, tick};
    shift_d = shift_q;
    bidx_d  = bidx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (tx_start) begin
        state_d = LEAD;
        shift_d = tx_data;
        bidx_d  = 3'd0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^tx_data;
`endif
      end
      LEAD:  if (tick && lcnt_q == 8'(LEAD_TICKS - 1)) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bidx_d  = bidx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bidx_q == 3'd7) state_d = PARITY;
`else
        if (bidx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP:  if (bit_end) state_d = GUARD;
      GUARD: if (tick && lcnt_q == 8'(GUARD_TICKS - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // every phase starts counting from zero; a tick on the accepting cycle is dropped
    if (state_d != state_q || state_q == IDLE) begin
      tcnt_d = 4'd0;
      lcnt_d = 8'd0;
    end
    txd_d = (state_d == START) ? 1'b0 :
            (state_d == DATA)  ? shift_d[0] :
`ifdef UART_TX_PARITY_EN
            (state_d == PARITY) ? par_d :
`endif
            1'b1;
  end
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clk16_q <= 1'b0;
      tcnt_q  <= 4'd0;
      lcnt_q  <= 8'd0;
      shift_q <= 8'd0;
      bidx_q  <= 3'd0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      clk16_q <= clk16;
      tcnt_q  <= tcnt_d;
      lcnt_q  <= lcnt_d;
      shift_q <= shift_d;
      bidx_q  <= bidx_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  assign txd      = txd_q;
  assign tx_done  = done_q;
  assign tx_ready = state_q == IDLE;
  assign de       = state_q != IDLE;
endmodule
